// File: rtl/hex_led_pkg.sv
// Shared types and constants for the HEX/LED display arbiter.
// The state and owner encodings match, so the owner port is a direct view of the state.
package hex_led_pkg;

  localparam int DIGIT_W  = 8;
  localparam int N_DIGITS = 6;
  localparam int HEX_W    = DIGIT_W * N_DIGITS;
  localparam int LED_W    = 8;

  localparam logic [HEX_W-1:0] HEX_BLANK = 48'hFFFF_FFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HPS  = 2'd1,
    FAB  = 2'd2
  } owner_t;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_OWN_HPS = 2'd1,
    S_OWN_FAB = 2'd2
  } state_t;

  function automatic owner_t owner_of(input state_t s);
    case (s)
      S_OWN_HPS: owner_of = HPS;
      S_OWN_FAB: owner_of = FAB;
      default:   owner_of = IDLE;
    endcase
  endfunction

  // Contended grant from IDLE goes to whichever requester did not own last.
  function automatic state_t rr_pick(input owner_t last);
    rr_pick = (last == HPS) ? S_OWN_FAB : S_OWN_HPS;
  endfunction

endpackage

// File: rtl/hps_change_det.sv
// Turns any change in the HPS PIO exports into a sticky pending request.
// A clear on the same cycle as a change wins, so changes seen while the HPS owns are absorbed.
module hps_change_det
  import hex_led_pkg::*;
#(
  parameter int DATA_W = HEX_W + LED_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] live,
  input  logic              clr,
  output logic              pend
);

  logic [DATA_W-1:0] live_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_p0 <= '0;
      pend    <= 1'b0;
    end else begin
      live_p0 <= live;
      if (clr) begin
        pend <= 1'b0;
      end else if (live != live_p0) begin
        pend <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_led_arbiter.sv
// Shares the six HEX digits and eight LEDs between the HPS PIOs and a fabric source,
// with a minimum ownership quantum and round-robin tie-breaking.
module hex_led_arbiter
  import hex_led_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50_000_000
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [HEX_W-1:0] hps_hex,
  input  logic [LED_W-1:0] hps_led,
  input  logic             fab_req,
  output logic             fab_gnt,
  input  logic [HEX_W-1:0] fab_hex,
  input  logic [LED_W-1:0] fab_led,
  output logic [HEX_W-1:0] hex_seg,
  output logic [LED_W-1:0] led,
  output logic [1:0]       owner
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

  state_t           state;
  state_t           state_nxt;
  owner_t           last_owner;
  logic [CNT_W-1:0] tenure_cnt;
  logic             expired;
  logic             hps_pend;
  logic             pend_clr;

  assign expired  = (tenure_cnt >= CNT_LAST);
  assign pend_clr = (state == S_OWN_HPS) || (state_nxt == S_OWN_HPS);

  hps_change_det #(
    .DATA_W (HEX_W + LED_W)
  ) u_change_det (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .live  ({hps_hex, hps_led}),
    .clr   (pend_clr),
    .pend  (hps_pend)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (hps_pend && fab_req) begin
          state_nxt = rr_pick(last_owner);
        end else if (hps_pend) begin
          state_nxt = S_OWN_HPS;
        end else if (fab_req) begin
          state_nxt = S_OWN_FAB;
        end
      end
      S_OWN_HPS: begin
        if (expired && fab_req) begin
          state_nxt = S_OWN_FAB;
        end
      end
      S_OWN_FAB: begin
        // A pending HPS change forces rotation even while the fabric still requests.
        if (expired) begin
          if (hps_pend) begin
            state_nxt = S_OWN_HPS;
          end else if (!fab_req) begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state      <= S_IDLE;
      tenure_cnt <= '0;
      last_owner <= FAB;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) begin
        tenure_cnt <= '0;
        if (state_nxt == S_OWN_HPS) begin
          last_owner <= HPS;
        end else if (state_nxt == S_OWN_FAB) begin
          last_owner <= FAB;
        end
      end else if (!expired) begin
        tenure_cnt <= tenure_cnt + CNT_W'(1);
      end
    end
  end

  // Output stage: follows the registered owner one cycle behind; IDLE holds the last image.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      hex_seg <= HEX_BLANK;
      led     <= '0;
    end else begin
      case (state)
        S_OWN_HPS: begin
          hex_seg <= hps_hex;
          led     <= hps_led;
        end
        S_OWN_FAB: begin
          hex_seg <= fab_hex;
          led     <= fab_led;
        end
        default: begin
          hex_seg <= hex_seg;
          led     <= led;
        end
      endcase
    end
  end

  assign owner   = owner_of(state);
  assign fab_gnt = (state == S_OWN_FAB);

endmodule

// File: tb/tb_hex_led_arbiter.sv
// Directed and randomized bench for hex_led_arbiter against a cycle-level ownership model.
module tb_hex_led_arbiter;

  localparam int HOLD = 4;

  logic        clk;
  logic        rst_n;
  logic [47:0] hps_hex;
  logic [7:0]  hps_led;
  logic        fab_req;
  logic        fab_gnt;
  logic [47:0] fab_hex;
  logic [7:0]  fab_led;
  logic [47:0] hex_seg;
  logic [7:0]  led;
  logic [1:0]  owner;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: owner as 0/1/2, cycles spent with the current owner, pending flag.
  int          m_owner;
  int          m_ticks;
  bit          m_pend;
  int          m_last;
  logic [55:0] m_prev;
  logic [47:0] m_hex;
  logic [7:0]  m_led;

  hex_led_arbiter #(
    .HOLD_CYCLES (HOLD)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .hps_hex       (hps_hex),
    .hps_led       (hps_led),
    .fab_req       (fab_req),
    .fab_gnt       (fab_gnt),
    .fab_hex       (fab_hex),
    .fab_led       (fab_led),
    .hex_seg       (hex_seg),
    .led           (led),
    .owner         (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0;
    m_ticks = 1;
    m_pend  = 1'b0;
    m_last  = 2;
    m_prev  = '0;
    m_hex   = 48'hFFFF_FFFF_FFFF;
    m_led   = 8'h00;
  endtask

  task automatic model_step();
    int nxt;
    bit done;
    bit changed;
    done    = (m_ticks >= HOLD);
    changed = ({hps_hex, hps_led} != m_prev);
    nxt     = m_owner;
    if (m_owner == 0) begin
      if (m_pend && fab_req) nxt = (m_last == 1) ? 2 : 1;
      else if (m_pend)       nxt = 1;
      else if (fab_req)      nxt = 2;
    end else if (m_owner == 1) begin
      if (done && fab_req) nxt = 2;
    end else begin
      if (done && (!fab_req || m_pend)) nxt = m_pend ? 1 : 0;
    end
    if (m_owner == 1) begin
      m_hex = hps_hex;
      m_led = hps_led;
    end else if (m_owner == 2) begin
      m_hex = fab_hex;
      m_led = fab_led;
    end
    m_pend = (nxt == 1 || m_owner == 1) ? 1'b0 : (m_pend | changed);
    m_prev = {hps_hex, hps_led};
    if (nxt != m_owner) begin
      m_ticks = 1;
      if (nxt != 0) m_last = nxt;
    end else if (m_ticks < 1000) begin
      m_ticks++;
    end
    m_owner = nxt;
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_owner"}, 64'(owner), 64'(m_owner));
    chk({tag, "_gnt"}, 64'(fab_gnt), 64'(m_owner == 2));
    chk({tag, "_hex"}, 64'(hex_seg), 64'(m_hex));
    chk({tag, "_led"}, 64'(led), 64'(m_led));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    @(negedge clk);
    compare_all("model");
  endtask

  initial begin
    rst_n   = 1'b0;
    hps_hex = '0;
    hps_led = '0;
    fab_req = 1'b0;
    fab_hex = '0;
    fab_led = '0;
    model_reset();
    repeat (2) cycle();
    rst_n = 1'b1;
    chk("rst_owner", 64'(owner), 64'd0);
    chk("rst_gnt", 64'(fab_gnt), 64'd0);
    chk("rst_hex", 64'(hex_seg), 64'hFFFF_FFFF_FFFF);
    chk("rst_led", 64'(led), 64'h00);

    // Fabric request from IDLE
    fab_hex = 48'h0102_0304_0506;
    fab_led = 8'hA5;
    fab_req = 1'b1;
    cycle();
    chk("fab_gnt_e1", 64'(fab_gnt), 64'd1);
    chk("fab_owner_e1", 64'(owner), 64'd2);
    chk("fab_hex_e1", 64'(hex_seg), 64'hFFFF_FFFF_FFFF);
    cycle();
    chk("fab_hex_e2", 64'(hex_seg), 64'h0102_0304_0506);
    chk("fab_led_e2", 64'(led), 64'hA5);

    // Asynchronous reset mid-tenure
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_hex", 64'(hex_seg), 64'hFFFF_FFFF_FFFF);
    chk("mid_rst_led", 64'(led), 64'h00);
    chk("mid_rst_owner", 64'(owner), 64'd0);
    chk("mid_rst_gnt", 64'(fab_gnt), 64'd0);
    cycle();
    fab_req = 1'b0;
    rst_n   = 1'b1;

    // Tie right after reset: HPS first, fabric after one quantum
    hps_led = 8'h11;
    cycle();
    chk("tie_owner_pend", 64'(owner), 64'd0);
    fab_req = 1'b1;
    cycle();
    chk("tie_owner_hps", 64'(owner), 64'd1);
    chk("tie_gnt_low", 64'(fab_gnt), 64'd0);
    for (int i = 0; i < HOLD - 1; i++) begin
      cycle();
      chk("tie_hold_hps", 64'(owner), 64'd1);
    end
    cycle();
    chk("tie_owner_fab", 64'(owner), 64'd2);
    chk("tie_gnt_high", 64'(fab_gnt), 64'd1);

    // HPS change in tenure cycle 1 of OWN_FAB forces rotation at expiry
    hps_led = 8'h22;
    for (int i = 0; i < HOLD - 1; i++) begin
      cycle();
      chk("rot_owner_fab", 64'(owner), 64'd2);
      chk("rot_gnt_high", 64'(fab_gnt), 64'd1);
    end
    cycle();
    chk("rot_owner_hps", 64'(owner), 64'd1);
    chk("rot_gnt_fall", 64'(fab_gnt), 64'd0);
    cycle();
    chk("rot_led_hps", 64'(led), 64'h22);

    // Fabric drops its request early: grant held until expiry, then IDLE holds fabric image
    repeat (HOLD - 1) cycle();
    chk("drop_owner_fab", 64'(owner), 64'd2);
    fab_req = 1'b0;
    for (int i = 0; i < HOLD - 1; i++) begin
      cycle();
      chk("drop_gnt_held", 64'(fab_gnt), 64'd1);
    end
    cycle();
    chk("drop_owner_idle", 64'(owner), 64'd0);
    chk("drop_gnt_low", 64'(fab_gnt), 64'd0);
    cycle();
    chk("drop_hex_hold", 64'(hex_seg), 64'h0102_0304_0506);
    chk("drop_led_hold", 64'(led), 64'hA5);

    // HPS change while HPS owns is absorbed and tracked live
    hps_led = 8'h5A;
    repeat (2) cycle();
    chk("abs_owner_hps", 64'(owner), 64'd1);
    hps_led = 8'h77;
    cycle();
    chk("abs_led_live", 64'(led), 64'h77);
    repeat (6) cycle();
    chk("abs_owner_keep", 64'(owner), 64'd1);

    // Randomized traffic with occasional asynchronous resets
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 7) == 0) fab_req = ~fab_req;
      if ($urandom_range(0, 5) == 0) begin
        hps_hex = {16'($urandom), $urandom};
        hps_led = 8'($urandom);
      end
      if (m_owner != 2 && $urandom_range(0, 3) == 0) begin
        fab_hex = {16'($urandom), $urandom};
        fab_led = 8'($urandom);
      end
      if ($urandom_range(0, 149) == 0) begin
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        compare_all("rnd_rst");
        cycle();
        rst_n = 1'b1;
      end else begin
        cycle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hex_led_arbiter.md
# hex_led_arbiter

Fabric-side arbiter that shares the board's six 7-segment digits and eight LEDs between two requesters: the HPS, through the hex0_3/hex4_5/led PIO exports, and a fabric status source. HPS requests are implied by any change in its PIO values. The fabric source uses an explicit req/gnt handshake. A tenure counter enforces a minimum ownership quantum, and round-robin ordering resolves contention. The block sits between the soc_system PIO exports and the HEX/LEDR board pins.

## Interface
Parameters:
- HOLD_CYCLES, 50_000_000, minimum ownership quantum in clk_clk cycles (1 s at 50 MHz); legal range ≥1.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous, active-low reset.
- hps_hex  in  48  HPS segment data: {hex4_5 export[15:0], hex0_3 export[31:0]}. 8 bits per digit, digit 0 in [7:0]. Active-low segments, bit 7 unused.
- hps_led  in  8  HPS LED data (led PIO export).
- fab_req  in  1  fabric request; level, held high while the fabric wants the display.
- fab_gnt  out  1  fabric grant.
- fab_hex  in  48  fabric segment data; same format as hps_hex.
- fab_led  in  8  fabric LED data.
- hex_seg  out  48  registered segment drive to the HEX5..HEX0 pins.
- led  out  8  registered LED drive.
- owner  out  2  current owner: 0 IDLE, 1 HPS, 2 FAB.

## Operation
- **Change detector:** registers {hps_hex, hps_led} every cycle.
  - When the live value differs from the registered copy, it sets the `hps_pend` flag.
  - `hps_pend` clears on the cycle the state enters OWN_HPS.
  - It also clears on every cycle while in OWN_HPS, because ownership implies live tracking.
- **States:** IDLE, OWN_HPS, OWN_FAB.
- **Transitions from IDLE:**
  - Only `hps_pend` → OWN_HPS.
  - Only `fab_req` → OWN_FAB.
  - Both → the requester that is not `last_owner`.
- **OWN_FAB:**
  - `fab_gnt` = 1.
  - Tenure counter counts up from 0; `expired` = (count ≥ HOLD_CYCLES−1).
  - After `expired`, if `fab_req`=0: go to OWN_HPS when `hps_pend`=1, otherwise IDLE.
  - After `expired`, if `fab_req`=1 and `hps_pend`=1: go to OWN_HPS (forced rotation).
  - Otherwise stay in OWN_FAB.
  - `fab_req` falling before expiry is honoured only at expiry; `fab_gnt` stays high until then.
- **OWN_HPS:**
  - After `expired`, if `fab_req`=1 → OWN_FAB.
  - Otherwise stay; the HPS keeps the display indefinitely when uncontested.
- **Tenure counter:** clears to 0 on every state change. Saturates at HOLD_CYCLES−1. Width $clog2(HOLD_CYCLES+1).
- **last_owner:** updated on entry to OWN_HPS or OWN_FAB. Reset value FAB, so the HPS wins the first tie.
- **Output data:**
  - hex_seg/led are loaded every cycle from the source selected by the registered state: HPS in OWN_HPS, FAB in OWN_FAB.
  - In IDLE they hold their last value.
- **Reset (asynchronous, any cycle, including mid-tenure):**
  - State IDLE, owner 0, fab_gnt 0, count 0, hps_pend 0, last_owner FAB.
  - Change-detect copy = 0.
  - hex_seg = 48'hFFFF_FFFF_FFFF (all blank), led = 8'h00.

## Timing
- Requests sampled at edge n → state, owner and fab_gnt update at edge n+1 → hex_seg/led show the new source at edge n+2.
- HPS value change at edge n → `hps_pend`=1 after edge n+1 → OWN_HPS no earlier than edge n+2.
- Minimum tenure: exactly HOLD_CYCLES cycles in OWN_x before any exit, counting the entry cycle.
- Handshake:
  - fab_gnt rises only when fab_req=1.
  - fab_gnt falls only at an expiry transition.
  - The fabric must keep fab_hex/fab_led valid for as long as fab_gnt=1.
- An HPS change arriving while OWN_HPS is active is absorbed, with no extra request. Its data appears on hex_seg one cycle later.

## Structure
- Package `hex_led_pkg`:
  - `owner_t` enum (IDLE=0, HPS=1, FAB=2).
  - `HEX_BLANK` = 48'hFFFF_FFFF_FFFF.
  - `DIGIT_W` = 8, `N_DIGITS` = 6.
- Sub-module `hps_change_det`: registered copy, compare, `hps_pend` set/clear.
- The FSM, tenure counter and output registers stay in the top module.

## Test plan
Use HOLD_CYCLES=4 throughout.
- Reset mid-tenure while in OWN_FAB:
  - Required: outputs immediately hex_seg=48'hFFFF_FFFF_FFFF, led=0, owner=0, fab_gnt=0.
- fab_req=1, fab_hex=48'h0102_0304_0506, fab_led=8'hA5 from IDLE:
  - Required: fab_gnt=1 after 1 edge; hex_seg/led match after 2 edges.
- hps_led 8'h00→8'h3C while IDLE:
  - Required: owner=1 after 2 edges; led=8'h3C after 3 edges.
  - fab_gnt stays 0.
- fab_req and hps_pend asserted in the same cycle right after reset:
  - Required: HPS is granted first.
  - After 4 cycles owner=2 and fab_gnt=1.
- OWN_FAB with fab_req held and an HPS change in cycle 1 of tenure:
  - Required: switch to owner=1 exactly after the 4th tenure cycle, with fab_gnt falling on the same edge.
- fab_req dropped in tenure cycle 1 with no HPS change:
  - Required: fab_gnt stays high until cycle 4, then owner=0.
  - Outputs hold the fabric values.
